alu_share_arbiter: RTL

Shares the single execute-stage ALU between two requesters (requester 0: EX stage; requester 1: address/auxiliary unit) over valid/ready handshakes. Round-robin grant, a registered issue stage driving the ALU, and a registered response stage returning result, status bits and requester ID. Sits between the requesters and the combinational ALU instance. The ALU itself is instantiated outside this block.

---
 rtl/alu_share_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two
// requesters (0 = EX stage, 1 = address/aux unit). It has two registered stages:
// issue (drives the ALU) and response (result, status, owner id).
// Optional macro ALU_ARB_FLAGS_EN: keeps an architectural {Z,C,N,V} flags
// register that ops with s=1 update and that supplies the ALU carry-in.
module alu_share_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter bit RESET_PTR  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic [WORD_WIDTH-1:0] req_val1_0,
  input  logic [WORD_WIDTH-1:0] req_val2_0,
  input  logic [3:0]            req_cmd_0,
  input  logic                  req_carry_0,
  input  logic                  req_s_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic [WORD_WIDTH-1:0] req_val1_1,
  input  logic [WORD_WIDTH-1:0] req_val2_1,
  input  logic [3:0]            req_cmd_1,
  input  logic                  req_carry_1,
  input  logic                  req_s_1,
  output logic [WORD_WIDTH-1:0] alu_val1,
  output logic [WORD_WIDTH-1:0] alu_val2,
  output logic [3:0]            alu_cmd,
  output logic                  alu_carry,
  input  logic [WORD_WIDTH-1:0] alu_res,
  input  logic [3:0]            alu_sr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [WORD_WIDTH-1:0] resp_res,
  output logic [3:0]            resp_sr
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic [3:0]            flags
`endif
);

  // ptr holds the last granted requester
  logic                  ptr_q, ptr_d;
  logic                  iss_valid_q, iss_valid_d;
  logic                  iss_id_q, iss_id_d;
  logic [WORD_WIDTH-1:0] iss_val1_q, iss_val1_d;
  logic [WORD_WIDTH-1:0] iss_val2_q, iss_val2_d;
  logic [3:0]            iss_cmd_q, iss_cmd_d;
  logic                  iss_carry_q, iss_carry_d;
  logic                  iss_s_q, iss_s_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_id_q, resp_id_d;
  logic [WORD_WIDTH-1:0] resp_res_q, resp_res_d;
  logic [3:0]            resp_sr_q, resp_sr_d;
  logic [3:0]            flags_q, flags_d;

  logic adv_resp, adv_iss, gnt0, gnt1, accept, resp_load;

  // Next-state: grant, issue-stage load/drain, response-stage load/drain
  always_comb begin
    adv_resp = ~resp_valid_q | resp_ready;
    adv_iss  = ~iss_valid_q | adv_resp;
    // on contention the requester that did not win last time goes first
    gnt1     = req_valid_1 & (~req_valid_0 | ~ptr_q);
    gnt0     = req_valid_0 & ~gnt1;
    accept   = (gnt0 | gnt1) & adv_iss;
    resp_load = iss_valid_q & adv_resp;

    ptr_d        = ptr_q;
    iss_valid_d  = iss_valid_q;
    iss_id_d     = iss_id_q;
    iss_val1_d   = iss_val1_q;
    iss_val2_d   = iss_val2_q;
    iss_cmd_d    = iss_cmd_q;
    iss_carry_d  = iss_carry_q;
    iss_s_d      = iss_s_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    resp_sr_d    = resp_sr_q;
    flags_d      = flags_q;

    if (accept) begin
      ptr_d       = gnt1;
      iss_valid_d = 1'b1;
      iss_id_d    = gnt1;
      iss_val1_d  = gnt1 ? req_val1_1  : req_val1_0;
      iss_val2_d  = gnt1 ? req_val2_1  : req_val2_0;
      iss_cmd_d   = gnt1 ? req_cmd_1   : req_cmd_0;
      iss_carry_d = gnt1 ? req_carry_1 : req_carry_0;
      iss_s_d     = gnt1 ? req_s_1     : req_s_0;
    end else if (adv_resp) begin
      // payload is kept so the ALU inputs do not toggle needlessly
      iss_valid_d = 1'b0;
    end

    if (resp_load) begin
      resp_valid_d = 1'b1;
      resp_id_d    = iss_id_q;
      resp_res_d   = alu_res;
      resp_sr_d    = alu_sr;
      if (iss_s_q) flags_d = alu_sr;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight op without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= ~RESET_PTR;
      iss_valid_q  <= 1'b0;
      iss_id_q     <= 1'b0;
      iss_val1_q   <= '0;
      iss_val2_q   <= '0;
      iss_cmd_q    <= '0;
      iss_carry_q  <= 1'b0;
      iss_s_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_res_q   <= '0;
      resp_sr_q    <= '0;
      flags_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      iss_valid_q  <= iss_valid_d;
      iss_id_q     <= iss_id_d;
      iss_val1_q   <= iss_val1_d;
      iss_val2_q   <= iss_val2_d;
      iss_cmd_q    <= iss_cmd_d;
      iss_carry_q  <= iss_carry_d;
      iss_s_q      <= iss_s_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
      resp_sr_q    <= resp_sr_d;
      flags_q      <= flags_d;
    end
  end

  assign req_ready_0 = gnt0 & adv_iss;
  assign req_ready_1 = gnt1 & adv_iss;
  assign alu_val1    = iss_val1_q;
  assign alu_val2    = iss_val2_q;
  assign alu_cmd     = iss_cmd_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_res    = resp_res_q;
  assign resp_sr     = resp_sr_q;

`ifdef ALU_ARB_FLAGS_EN
  // carry comes from the architectural flags, updated on the response edge,
  // so a dependent op right behind a flag-setting op sees the new carry
  assign alu_carry = flags_q[2];
  assign flags     = flags_q;
  logic unused_carry;
  assign unused_carry = iss_carry_q;
`else
  // per-request carry; s and the flags register have no effect here
  assign alu_carry = iss_carry_q;
  logic unused_flags;
  assign unused_flags = ^{iss_s_q, flags_q};
`endif

endmodule
